alu_result_display: RTL and testbench

- Consumer end of the ALU result interface: captures the 16-bit `res`/`isValid` pair on a load strobe from the calculator controller.
- Converts the captured value to BCD with a sequential double-dabble engine.
- Drives a time-multiplexed, active-low 7-segment display.
- Sits between the ALU output and the board display pins.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 39 +++
 rtl/alu_result_display.sv | 191 +++++++++++++++++++
 tb/tb_alu_result_display.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: result width, display FSM states and
// active-low 7-segment codes ordered {a,b,c,d,e,f,g}.
package calc_pkg;

    // Result width shared with the ALU res bus
    localparam int unsigned RES_W_DEF = 16;

    // Conversion FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Digit glyphs, segment on = 0
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    // Special glyphs
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_E     = 7'b0110000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with E / dash / blank overrides.
// Priority: ecode > dash > blank > digit. Nibbles above 9 show blank.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    input  logic       dash,
    input  logic       ecode,
    output logic [6:0] seg_c
);

    // Select glyph for the current digit
    always_comb begin
        seg_c = SEG_BLANK;
        if (ecode) begin
            seg_c = SEG_E;
        end else if (dash) begin
            seg_c = SEG_DASH;
        end else if (blank) begin
            seg_c = SEG_BLANK;
        end else begin
            case (nib)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_display.sv
// ALU result display: captures res/isValid on load, converts to BCD with a
// bit-serial double-dabble engine, and scans an active-low 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0
// is never blanked); the default build shows every digit.
module alu_result_display
    import calc_pkg::*;
#(
    parameter int unsigned RES_W    = RES_W_DEF,
    parameter int unsigned DIGITS   = 5,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RES_W-1:0]      res,
    input  logic                  isValid,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CAT_W = BCD_W + RES_W;
    localparam int unsigned BIT_W = (RES_W > 1) ? $clog2(RES_W) : 1;
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state, state_nxt;
    logic [RES_W-1:0]   shreg, shreg_nxt;
    logic [BCD_W-1:0]   scratch, scratch_nxt;
    logic [BCD_W-1:0]   adj;
    logic [CAT_W-1:0]   shifted;
    logic [BIT_W-1:0]   bitcnt, bitcnt_nxt;
    logic               conv_ok, conv_ok_nxt;
    logic               busy_nxt, done_nxt, err_nxt;
    logic [BCD_W-1:0]   bcd_nxt;

    logic [CNT_W-1:0]   scan_cnt, scan_cnt_nxt;
    logic [IDX_W-1:0]   dig_idx, dig_idx_nxt;
    logic [DIGITS-1:0]  an_nxt;
    logic [3:0]         cur_nib;
    logic               blank_sel, dash_sel, e_sel;
    logic [6:0]         seg_c;

    // Conversion FSM next-state and datapath
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        scratch_nxt = scratch;
        bitcnt_nxt  = bitcnt;
        conv_ok_nxt = conv_ok;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = err;
        bcd_nxt     = bcd;
        adj         = scratch;

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, shreg} << 1;

        case (state)
            IDLE: begin
                if (load) begin
                    if (isValid) begin
                        shreg_nxt   = res;
                        scratch_nxt = '0;
                        bitcnt_nxt  = BIT_W'(RES_W - 1);
                        conv_ok_nxt = 1'b1;
                        busy_nxt    = 1'b1;
                        state_nxt   = SHIFT;
                    end else begin
                        conv_ok_nxt = 1'b0;
                        err_nxt     = 1'b1;
                        state_nxt   = DONE;
                    end
                end
            end
            SHIFT: begin
                scratch_nxt = shifted[CAT_W-1:RES_W];
                shreg_nxt   = shifted[RES_W-1:0];
                bitcnt_nxt  = bitcnt - BIT_W'(1);
                if (bitcnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                if (conv_ok) begin
                    bcd_nxt = scratch;
                    err_nxt = 1'b0;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Conversion state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            bitcnt  <= '0;
            conv_ok <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bcd     <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            scratch <= scratch_nxt;
            bitcnt  <= bitcnt_nxt;
            conv_ok <= conv_ok_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            bcd     <= bcd_nxt;
        end
    end

    // Scan timing and per-digit glyph selection from the committed result
    always_comb begin
        scan_cnt_nxt = scan_cnt + CNT_W'(1);
        dig_idx_nxt  = dig_idx;
        if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_nxt = '0;
            dig_idx_nxt  = (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
        end

        cur_nib = bcd[3:0];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (dig_idx == IDX_W'(i)) begin
                cur_nib = bcd[4*i +: 4];
            end
        end

        e_sel     = err && (dig_idx == '0);
        dash_sel  = err && (dig_idx != '0);
        blank_sel = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = int'(DIGITS) - 1; i > 0; i--) begin
                lead = lead && (bcd[4*i +: 4] == 4'd0);
                if (dig_idx == IDX_W'(i)) begin
                    blank_sel = lead;
                end
            end
        end
`endif

        an_nxt = ~(DIGITS'(1) << dig_idx);
    end

    seg7_decode u_seg7_decode (
        .nib   (cur_nib),
        .blank (blank_sel),
        .dash  (dash_sel),
        .ecode (e_sel),
        .seg_c (seg_c)
    );

    // Scan counter, digit index and registered display pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            an       <= ~DIGITS'(1);
            seg      <= SEG_0;
        end else begin
            scan_cnt <= scan_cnt_nxt;
            dig_idx  <= dig_idx_nxt;
            an       <= an_nxt;
            seg      <= seg_c;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display with a fast scan divider.
module tb_alu_result_display;

    localparam int RW  = 16;
    localparam int DG  = 5;
    localparam int DIV = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [RW-1:0]   res = '0;
    logic            isValid = 1'b0;
    logic            load = 1'b0;
    logic            busy, done, err;
    logic [4*DG-1:0] bcd;
    logic [6:0]      seg;
    logic [DG-1:0]   an;

    alu_result_display #(.RES_W(RW), .DIGITS(DG), .SCAN_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .res(res), .isValid(isValid), .load(load),
        .busy(busy), .done(done), .err(err), .bcd(bcd), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4*DG-1:0] bcd;
        logic            err;
        int              due;
    } exp_t;
    exp_t sb[$];

    logic [4*DG-1:0] m_bcd = '0;
    logic            m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal digits by plain arithmetic
    function automatic logic [4*DG-1:0] to_bcd(input int v);
        logic [4*DG-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected glyph for digit position idx from the model state
    function automatic logic [6:0] exp_seg(input int idx);
        int hi;
        if (m_err) return (idx == 0) ? 7'b0110000 : 7'b1111110;
        hi = 0;
        for (int i = 0; i < DG; i++) if (m_bcd[4*i +: 4] != 4'd0) hi = i;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > hi) return 7'b1111111;
`endif
        return glyph(int'(m_bcd[4*idx +: 4]));
    endfunction

    // Monitor: every done pulse must match the oldest expected result
    exp_t e_mon;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e_mon = sb.pop_front();
                check("done_bcd", 32'(bcd), 32'(e_mon.bcd));
                check("done_err", 32'(err), 32'(e_mon.err));
                check("done_latency", cyc, e_mon.due);
                check("done_busy", 32'(busy), 32'd0);
            end
        end
    end

    task automatic issue(input logic [RW-1:0] v, input logic valid);
        exp_t e;
        @(negedge clk);
        res = v; isValid = valid; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (valid) begin
            m_bcd = to_bcd(int'(v));
            m_err = 1'b0;
            e.due = cyc + RW + 1;
        end else begin
            m_err = 1'b1;
            e.due = cyc + 1;
        end
        e.bcd = m_bcd;
        e.err = m_err;
        sb.push_back(e);
        check("busy_after_load", 32'(busy), 32'(valid));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got %0d pending expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic check_scan();
        int prev = -1;
        int run = 0;
        int nchg = 0;
        int idx;
        repeat (45) begin
            @(negedge clk);
            idx = -1;
            for (int i = 0; i < DG; i++) if (an == ~(DG'(1) << i)) idx = i;
            check("an_onehot", 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                check("seg_digit", 32'(seg), 32'(exp_seg(idx)));
                if (idx != prev) begin
                    if (prev >= 0) begin
                        check("an_order", idx, (prev + 1) % DG);
                        if (nchg > 0) check("an_dwell", run, DIV);
                        nchg++;
                    end
                    prev = idx;
                    run = 1;
                end else begin
                    run++;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_an", 32'(an), 32'b11110);
        check("rst_seg", 32'(seg), 32'b0000001);

        issue(16'd6, 1'b1);     wait_idle();
        issue(16'hFFFF, 1'b1);  wait_idle();
        issue(16'd1000, 1'b1);  wait_idle();
        issue(16'd0, 1'b1);     wait_idle();
        check_scan();
        issue(16'd42, 1'b1);    wait_idle();
        check_scan();

        issue(16'd123, 1'b0);   wait_idle();
        check("err_level", 32'(err), 32'd1);
        check("err_bcd_kept", 32'(bcd), 32'h00042);
        check_scan();

        // Load during conversion is dropped
        issue(16'd999, 1'b1);
        repeat (4) @(negedge clk);
        check("busy_mid", 32'(busy), 32'd1);
        res = 16'd5; isValid = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle();

        // Reset mid-conversion aborts without a done pulse
        issue(16'd999, 1'b1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        m_bcd = '0;
        m_err = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_bcd", 32'(bcd), 32'd0);

        for (int k = 0; k < 25; k++) begin
            issue(RW'($urandom_range(0, 65535)), ($urandom_range(0, 4) != 0));
            wait_idle();
        end
        check_scan();

        wait_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
